bp_table_scheduler: RTL and testbench

Scheduler for a single-port pattern history table (PHT) of saturating counters, shared between decode-stage prediction lookups and execute-stage feedback updates. After reset it sweeps the table to a known value. It then gives lookups priority for the one table port, and buffers updates in a small queue that it drains as read-modify-write pairs. It sits between `branch_controller` and the PHT SRAM, so the predictor no longer needs a multi-ported, one-cycle-reset counter array.

---
 rtl/mips_core_pkg.sv | 16 +
 rtl/bp_update_queue.sv | 63 ++++++
 rtl/bp_table_scheduler.sv | 143 ++++++++++++++
 tb/tb_bp_table_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types: the resolved branch outcome and the PHT scheduler state.
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_RD = 2'd2,
    UPD_WR = 2'd3
  } bp_sched_state_e;

endpackage

// File: rtl/bp_update_queue.sv
// Small synchronous FIFO of pending PHT updates ({index, outcome}).
module bp_update_queue
  import mips_core_pkg::*;
#(
  parameter int INDEX_WIDTH = 10,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [INDEX_WIDTH-1:0] push_index,
  input  BranchOutcome           push_outcome,
  input  logic                   pop,
  output logic [INDEX_WIDTH-1:0] head_index,
  output BranchOutcome           head_outcome,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INDEX_WIDTH-1:0] index_mem   [DEPTH];
  BranchOutcome           outcome_mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q;
  logic [PTR_W-1:0]       rd_ptr_q;
  logic [PTR_W:0]         count_q;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: the storage array has no reset; the pointers and count alone decide
  // which entries are live, so a reset flushes the queue without clearing data.
  always_ff @(posedge clk) begin
    if (do_push) begin
      index_mem[wr_ptr_q]   <= push_index;
      outcome_mem[wr_ptr_q] <= push_outcome;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_index   = index_mem[rd_ptr_q];
  assign head_outcome = outcome_mem[rd_ptr_q];

endmodule

// File: rtl/bp_table_scheduler.sv
// Arbitrates the single PHT SRAM port: init sweep, priority lookups, and
// queued read-modify-write counter updates.
module bp_table_scheduler
  import mips_core_pkg::*;
#(
  parameter int                   INDEX_WIDTH = 10,
  parameter int                   CTR_WIDTH   = 2,
  parameter int                   UPD_DEPTH   = 4,
  parameter logic [CTR_WIDTH-1:0] INIT_VALUE  = CTR_WIDTH'('b01)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_lookup_valid,
  input  logic [INDEX_WIDTH-1:0] i_lookup_index,
  output logic                   o_lookup_ready,
  output logic                   o_lookup_rvalid,
  output logic [CTR_WIDTH-1:0]   o_lookup_counter,
  input  logic                   i_update_valid,
  input  logic [INDEX_WIDTH-1:0] i_update_index,
  input  BranchOutcome           i_update_outcome,
  output logic                   o_update_ready,
  output logic                   o_tbl_en,
  output logic                   o_tbl_we,
  output logic [INDEX_WIDTH-1:0] o_tbl_addr,
  output logic [CTR_WIDTH-1:0]   o_tbl_wdata,
  input  logic [CTR_WIDTH-1:0]   i_tbl_rdata,
  output logic                   o_busy
);

  function automatic logic [CTR_WIDTH-1:0] sat_next(input logic [CTR_WIDTH-1:0] ctr,
                                                    input BranchOutcome outcome);
    if (outcome == TAKEN) return (&ctr) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  bp_sched_state_e        state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_addr_q;
  logic                   rvalid_q;
  logic [CTR_WIDTH-1:0]   ctr_hold_q;

  logic                   q_full, q_empty, q_push, q_pop;
  logic [INDEX_WIDTH-1:0] head_index;
  BranchOutcome           head_outcome;

  logic                   lookup_ready, lookup_fire;
  logic                   tbl_en, tbl_we;
  logic [INDEX_WIDTH-1:0] tbl_addr;
  logic [CTR_WIDTH-1:0]   tbl_wdata;

  assign o_update_ready = (state_q != INIT) & ~q_full;
  assign q_push         = i_update_valid & o_update_ready;

  bp_update_queue #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .DEPTH       (UPD_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (q_push),
    .push_index   (i_update_index),
    .push_outcome (i_update_outcome),
    .pop          (q_pop),
    .head_index   (head_index),
    .head_outcome (head_outcome),
    .full         (q_full),
    .empty        (q_empty)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_addr_q <= '0;
      rvalid_q    <= 1'b0;
      ctr_hold_q  <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= lookup_fire;
      if (state_q == INIT) init_addr_q <= init_addr_q + 1'b1;
      if (rvalid_q)        ctr_hold_q  <= i_tbl_rdata;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    lookup_ready = 1'b0;
    lookup_fire  = 1'b0;
    q_pop        = 1'b0;
    tbl_en       = 1'b0;
    tbl_we       = 1'b0;
    tbl_addr     = '0;
    tbl_wdata    = '0;
    case (state_q)
      INIT: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = init_addr_q;
        tbl_wdata = INIT_VALUE;
        if (&init_addr_q) state_d = IDLE;
      end
      IDLE: begin
        // A full queue blocks lookups so the head update cannot starve.
        lookup_ready = ~q_full;
        if (i_lookup_valid && !q_full) begin
          lookup_fire = 1'b1;
          tbl_en      = 1'b1;
          tbl_addr    = i_lookup_index;
        end else if (!q_empty) begin
          state_d = UPD_RD;
        end
      end
      UPD_RD: begin
        tbl_en   = 1'b1;
        tbl_addr = head_index;
        state_d  = UPD_WR;
      end
      UPD_WR: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = head_index;
        tbl_wdata = sat_next(i_tbl_rdata, head_outcome);
        q_pop     = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  // The SRAM port is held quiet for as long as reset is asserted.
  assign o_tbl_en    = rst_n & tbl_en;
  assign o_tbl_we    = rst_n & tbl_we;
  assign o_tbl_addr  = rst_n ? tbl_addr : '0;
  assign o_tbl_wdata = rst_n ? tbl_wdata : '0;

  assign o_lookup_ready   = lookup_ready;
  assign o_lookup_rvalid  = rvalid_q;
  assign o_lookup_counter = rvalid_q ? i_tbl_rdata : ctr_hold_q;
  assign o_busy           = (state_q == INIT);

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Scoreboard bench for bp_table_scheduler with a 16-entry behavioural SRAM.
module tb_bp_table_scheduler;
  import mips_core_pkg::*;

  logic         clk;
  logic         rst_n;
  logic         i_lookup_valid;
  logic [3:0]   i_lookup_index;
  logic         o_lookup_ready;
  logic         o_lookup_rvalid;
  logic [1:0]   o_lookup_counter;
  logic         i_update_valid;
  logic [3:0]   i_update_index;
  BranchOutcome i_update_outcome;
  logic         o_update_ready;
  logic         o_tbl_en;
  logic         o_tbl_we;
  logic [3:0]   o_tbl_addr;
  logic [1:0]   o_tbl_wdata;
  logic [1:0]   i_tbl_rdata;
  logic         o_busy;

  bp_table_scheduler #(
    .INDEX_WIDTH (4),
    .CTR_WIDTH   (2),
    .UPD_DEPTH   (4),
    .INIT_VALUE  (2'b01)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_lookup_valid   (i_lookup_valid),
    .i_lookup_index   (i_lookup_index),
    .o_lookup_ready   (o_lookup_ready),
    .o_lookup_rvalid  (o_lookup_rvalid),
    .o_lookup_counter (o_lookup_counter),
    .i_update_valid   (i_update_valid),
    .i_update_index   (i_update_index),
    .i_update_outcome (i_update_outcome),
    .o_update_ready   (o_update_ready),
    .o_tbl_en         (o_tbl_en),
    .o_tbl_we         (o_tbl_we),
    .o_tbl_addr       (o_tbl_addr),
    .o_tbl_wdata      (o_tbl_wdata),
    .i_tbl_rdata      (i_tbl_rdata),
    .o_busy           (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port SRAM.
  logic [1:0] mem [16];
  always @(posedge clk) begin
    if (o_tbl_en) begin
      if (o_tbl_we) mem[o_tbl_addr] <= o_tbl_wdata;
      else          i_tbl_rdata     <= mem[o_tbl_addr];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input BranchOutcome o);
    if (o == TAKEN) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  typedef struct {
    logic [3:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t        exp_wr_q [$];
  logic [1:0] exp_lk_q [$];
  logic [1:0] seq_model [16];  // table after every enqueued update is applied
  logic [1:0] applied   [16];  // table after the writes seen so far
  logic       lk_pending = 1'b0;
  wr_t        mon_e;
  logic [1:0] mon_nv;

  // Monitor: pops before pushes, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_wr_q.delete();
      exp_lk_q.delete();
      lk_pending = 1'b0;
    end else if (!o_busy) begin
      check("lk_rvalid", o_lookup_rvalid, lk_pending);
      if (o_lookup_rvalid) begin
        if (exp_lk_q.size() == 0) check("lk_unexp", o_lookup_rvalid, 0);
        else check("lk_data", o_lookup_counter, exp_lk_q.pop_front());
      end
      if (o_tbl_en && o_tbl_we) begin
        if (exp_wr_q.size() == 0) check("wr_unexp", o_tbl_we, 0);
        else begin
          mon_e = exp_wr_q.pop_front();
          check("wr_addr", o_tbl_addr, mon_e.addr);
          check("wr_data", o_tbl_wdata, mon_e.data);
          applied[mon_e.addr] = mon_e.data;
        end
      end
      lk_pending = i_lookup_valid && o_lookup_ready;
      if (lk_pending) exp_lk_q.push_back(applied[i_lookup_index]);
      if (i_update_valid && o_update_ready) begin
        mon_nv = next_ctr(seq_model[i_update_index], i_update_outcome);
        seq_model[i_update_index] = mon_nv;
        exp_wr_q.push_back('{addr: i_update_index, data: mon_nv});
      end
    end
  end

  task automatic init_models();
    for (int i = 0; i < 16; i++) begin
      seq_model[i] = 2'b01;
      applied[i]   = 2'b01;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check(tag, {o_busy, o_lookup_ready, o_update_ready, o_lookup_rvalid, o_lookup_counter,
                o_tbl_en, o_tbl_we, o_tbl_addr, o_tbl_wdata}, {1'b1, 13'd0});
  endtask

  // Called just after the edge where rst_n rises.
  task automatic check_sweep();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("init_busy", o_busy, 1);
      check("init_rdy", {o_lookup_ready, o_update_ready}, 2'b00);
      check("init_wr", {o_tbl_en, o_tbl_we, o_tbl_addr, o_tbl_wdata}, {1'b1, 1'b1, 4'(i), 2'b01});
    end
    @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_rdy", {o_lookup_ready, o_update_ready}, 2'b11);
    @(posedge clk); #1;
  endtask

  task automatic do_lookup(input logic [3:0] idx);
    int n = 0;
    i_lookup_valid = 1'b1;
    i_lookup_index = idx;
    @(negedge clk);
    while (!o_lookup_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("lk_accept_to", o_lookup_ready, 1);
    @(posedge clk); #1;
    i_lookup_valid = 1'b0;
  endtask

  task automatic do_update(input logic [3:0] idx, input BranchOutcome o);
    int n = 0;
    i_update_valid   = 1'b1;
    i_update_index   = idx;
    i_update_outcome = o;
    @(negedge clk);
    while (!o_update_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) check("upd_accept_to", o_update_ready, 1);
    @(posedge clk); #1;
    i_update_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_wr_q.size() != 0 || exp_lk_q.size() != 0 || lk_pending) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("drain_to", exp_wr_q.size() + exp_lk_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic fill_queue(input logic [3:0] idx0, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      i_update_valid   = 1'b1;
      i_update_index   = idx0 + 4'(k);
      i_update_outcome = (k % 2 == 0) ? TAKEN : NOT_TAKEN;
      @(negedge clk);
      check("fill_urdy", o_update_ready, 1);
      @(posedge clk); #1;
    end
    i_update_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cycles;
    rst_n            = 1'b0;
    i_lookup_valid   = 1'b0;
    i_lookup_index   = '0;
    i_update_valid   = 1'b0;
    i_update_index   = '0;
    i_update_outcome = NOT_TAKEN;
    init_models();

    repeat (3) @(negedge clk);
    check_reset_vals("rst_outs");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();

    do_lookup(4'd7);
    wait_drain();
    check("lk7_hold", o_lookup_counter, 2'b01);

    // Saturating increments on index 3.
    repeat (3) do_update(4'd3, TAKEN);
    wait_drain();
    do_lookup(4'd3);
    wait_drain();
    check("lk3_hold", o_lookup_counter, 2'b11);

    // Saturating decrements on index 5.
    repeat (2) do_update(4'd5, NOT_TAKEN);
    wait_drain();
    do_lookup(4'd5);
    wait_drain();
    check("lk5_hold", o_lookup_counter, 2'b00);

    // Continuous lookups while the queue fills to 4.
    i_lookup_valid = 1'b1;
    i_lookup_index = 4'd9;
    fill_queue(4'd1, 4);
    @(negedge clk);
    cycles = 1;
    check("full_lrdy", o_lookup_ready, 0);
    check("full_urdy", o_update_ready, 0);
    @(negedge clk);
    cycles++;
    check("rd_lrdy", o_lookup_ready, 0);
    check("rd_port", {o_tbl_en, o_tbl_we}, 2'b10);
    @(negedge clk);
    cycles++;
    check("wr_lrdy", o_lookup_ready, 0);
    check("wr_port", {o_tbl_en, o_tbl_we}, 2'b11);
    @(posedge clk); #1;
    i_lookup_valid = 1'b0;
    @(negedge clk);
    cycles++;
    check("pop_urdy", o_update_ready, 1);
    #1;
    while (exp_wr_q.size() != 0 && cycles < 12) begin
      @(negedge clk); #1;
      cycles++;
    end
    check("all4_in_12", exp_wr_q.size(), 0);
    wait_drain();

    // Reset while the first of 3 queued updates is in its write cycle.
    i_lookup_valid = 1'b1;
    i_lookup_index = 4'd12;
    fill_queue(4'd6, 3);
    i_lookup_valid = 1'b0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(o_tbl_en && o_tbl_we) && cycles < 20);
    check("rmw_wr_seen", {o_tbl_we, o_tbl_addr}, {1'b1, 4'd6});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst_outs");
    init_models();
    repeat (2) @(negedge clk);
    check_reset_vals("midrst_hold");
    check("mem6_kept", mem[6], 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_sweep();
    repeat (6) begin
      @(negedge clk);
      check("no_stale_upd", o_tbl_en, 0);
    end
    @(posedge clk); #1;
    do_lookup(4'd6);
    wait_drain();
    check("lk6_hold", o_lookup_counter, 2'b01);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
